flipflop_excitation_seq: RTL and testbench
==========================================

FLIPFLOP_EXCITATION_SEQ -- requirements
Module: flipflop_excitation_seq

Interface
REQ-001 Parameter: WIDTH, default 4, number of flip-flops in the driven bank and width of the target word.
REQ-002 Parameter: CNT_W, default 8, width of the saturating toggle counter.
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: tgt_valid  input  1  target word present.
REQ-006 Port: tgt_ready  output  1  block can accept a target word.
REQ-007 Port: tgt_data  input  WIDTH  desired next state of the flop bank.
REQ-008 Port: mode  input  1  excitation style: 0 = JK (toggle), 1 = SR (set/reset); sampled with tgt_data.
REQ-009 Port: j  output  WIDTH  J (SR mode: S) excitation applied to the bank.
REQ-010 Port: k  output  WIDTH  K (SR mode: R) excitation applied to the bank.
REQ-011 Port: q  output  WIDTH  current flop-bank state.
REQ-012 Port: done  output  1  one-cycle pulse: operation complete.
REQ-013 Port: err  output  1  one-cycle pulse, coincident with done: q differs from target.
REQ-014 Port: tog_cnt  output  CNT_W  saturating count of bits driven with J=K=1.

Function
REQ-015 The block SHALL run an FSM with states IDLE, DRIVE, CHECK.
REQ-016 tgt_ready SHALL be 1 only in IDLE; tgt_valid is ignored in DRIVE and CHECK.
REQ-017 On a rising edge with tgt_valid=1 in IDLE, the block SHALL register tgt_data and mode and enter DRIVE.
REQ-018 DRIVE SHALL last exactly one cycle, then enter CHECK; CHECK SHALL last exactly one cycle, then enter IDLE.
REQ-019 In DRIVE, JK mode: per bit, j=k=1 if target differs from q, else j=k=0.
REQ-020 In DRIVE, SR mode: per bit, (j,k)=(1,0) for 0->1, (0,1) for 1->0, (0,0) if unchanged; (1,1) SHALL never be produced.
REQ-021 Outside DRIVE, j and k SHALL be all zeros (bank holds).
REQ-022 The bank SHALL update on the edge ending DRIVE, with JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-023 In CHECK, done SHALL be 1; err SHALL be 1 iff q != registered target.
REQ-024 Latency: done asserts in the second cycle after the accepting edge; throughput one word per 3 cycles.
REQ-025 At the edge ending DRIVE, tog_cnt SHALL add popcount(j & k), saturating at 2^CNT_W-1, never wrapping.
REQ-026 A target equal to current q SHALL still run the full sequence with j=k=0, done=1, err=0, no counter change.

Reset
REQ-027 With rst=0, asynchronously: state=IDLE, q=0, registered target=0, mode=0, tog_cnt=0, done=0, err=0, j=k=0.
REQ-028 tgt_ready SHALL be 1 in the first cycle after reset release.
REQ-029 Reset during DRIVE or CHECK SHALL abort the operation; no done pulse SHALL follow for it.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, DRIVE, CHECK) and the mode constants MODE_JK=0, MODE_SR=1.
REQ-031 The flop bank SHALL be a sub-module jk_bank (WIDTH JK flops with q and q_bar, async active-low reset to q=0).
REQ-032 Excitation logic and counter SHALL stay in the top module.

Verification
REQ-033 Reset, then accept 4'b1010 in JK mode -> DRIVE: j=k=1010; CHECK: q=1010, done=1, err=0; tog_cnt=2.
REQ-034 From q=1010, accept 4'b0110 in SR mode -> DRIVE: j=0100, k=1000; CHECK: q=0110, done=1, err=0; tog_cnt=2.
REQ-035 Accept 4'b0110 again -> j=k=0000, done=1, err=0, tog_cnt unchanged.
REQ-036 Alternate 0000/1111 in JK mode 70 times -> tog_cnt=255 and holds; done on every third cycle.
REQ-037 Hold tgt_valid=1 for 9 cycles -> exactly 3 acceptances; tgt_ready=0 in every DRIVE and CHECK cycle.
REQ-038 Assert rst in DRIVE -> q=0000 and tog_cnt=0 immediately, no done pulse; tgt_ready=1 the cycle after release.

Source files
------------

// File: rtl/flipflop_excitation_seq_pkg.sv
// Shared types for the flip-flop excitation sequencer: FSM state encoding
// and excitation-style constants.
package flipflop_excitation_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic MODE_JK = 1'b0;
  localparam logic MODE_SR = 1'b1;

endpackage

// File: rtl/flipflop_excitation_seq_jk_bank.sv
// Bank of WIDTH JK flip-flops with true and complement outputs.
// Asynchronous active-low reset clears every flop to q=0.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   w_q_next[i] = 1'b0;
        2'b10:   w_q_next[i] = 1'b1;
        2'b11:   w_q_next[i] = ~r_q[i];
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule

// File: rtl/flipflop_excitation_seq.sv
// Accepts a target word, drives JK or SR excitation into a flop bank for one
// cycle, then reports completion and whether the bank reached the target.
module flipflop_excitation_seq
  import flipflop_excitation_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] tog_cnt,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_tgt;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_bar;
  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  // Handshake: a word transfers on a rising edge where tgt_valid and
  // tgt_ready are both 1; tgt_ready is high only in IDLE.
  assign tgt_ready = (r_state == IDLE);
  assign w_accept  = tgt_ready && tgt_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = DRIVE;
      DRIVE:   w_next_state = CHECK;
      CHECK:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // SR excitation uses q_bar/q so set and reset are mutually exclusive per bit.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == DRIVE) begin
      if (r_mode == MODE_JK) begin
        w_j = r_tgt ^ w_q;
        w_k = r_tgt ^ w_q;
      end else begin
        w_j = r_tgt & w_q_bar;
        w_k = ~r_tgt & w_q;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + (CNT_W + 1)'(w_j[i] & w_k[i]);
    end
    w_sum      = {1'b0, r_cnt} + w_pop;
    w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_mode  <= MODE_JK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_tgt  <= tgt_data;
        r_mode <= mode;
      end
      if (r_state == DRIVE) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clock (clock),
    .rst   (rst),
    .j     (w_j),
    .k     (w_k),
    .q     (w_q),
    .q_bar (w_q_bar)
  );

  assign j         = w_j;
  assign k         = w_k;
  assign q         = w_q;
  assign done      = (r_state == CHECK);
  assign err       = (r_state == CHECK) && (w_q != r_tgt);
  assign tog_cnt   = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_flipflop_excitation_seq.sv
// Scoreboard bench for flipflop_excitation_seq: directed vectors push
// expected DRIVE/CHECK responses, a negedge monitor pops and compares.
module tb_flipflop_excitation_seq;
  import flipflop_excitation_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             rst;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic             mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] tog_cnt;
  state_t           dbg_state;

  logic [2*WIDTH-1:0]     exp_jk_q[$];
  logic [WIDTH+CNT_W:0]   exp_chk_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_drive = 0;
  int n_done = 0;
  int last_done = -1;
  bit gap_en = 0;

  flipflop_excitation_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .mode      (mode),
    .j         (j),
    .k         (k),
    .q         (q),
    .done      (done),
    .err       (err),
    .tog_cnt   (tog_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [2*WIDTH-1:0]   e_jk;
    logic [WIDTH+CNT_W:0] e_chk;
    if (rst) begin
      if (dbg_state != IDLE) chk("ready_low", 32'(tgt_ready), 32'd0);
      if (dbg_state == DRIVE) begin
        n_drive++;
        if (exp_jk_q.size() == 0) begin
          flag("drive_unexpected");
        end else begin
          e_jk = exp_jk_q.pop_front();
          chk("j", 32'(j), 32'(e_jk[2*WIDTH-1:WIDTH]));
          chk("k", 32'(k), 32'(e_jk[WIDTH-1:0]));
        end
      end
      if (done) begin
        n_done++;
        if (gap_en && last_done >= 0) chk("done_gap", 32'(cyc - last_done), 32'd3);
        last_done = cyc;
        if (exp_chk_q.size() == 0) begin
          flag("done_unexpected");
        end else begin
          e_chk = exp_chk_q.pop_front();
          chk("q", 32'(q), 32'(e_chk[WIDTH+CNT_W:CNT_W+1]));
          chk("err", 32'(err), 32'(e_chk[CNT_W]));
          chk("tog_cnt", 32'(tog_cnt), 32'(e_chk[CNT_W-1:0]));
        end
      end
    end
  end

  // driver: waits for ready (bounded), pushes expectations, takes one edge
  task automatic send(input logic [WIDTH-1:0] d, input logic m,
                      input logic [WIDTH-1:0] ej, input logic [WIDTH-1:0] ek,
                      input logic [WIDTH-1:0] eq, input logic [CNT_W-1:0] ecnt);
    int n = 0;
    tgt_data  = d;
    mode      = m;
    tgt_valid = 1'b1;
    while (!tgt_ready && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    if (!tgt_ready) flag("ready_timeout");
    exp_jk_q.push_back({ej, ek});
    exp_chk_q.push_back({eq, 1'b0, ecnt});
    @(posedge clock); #1;
    tgt_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_jk_q.size() != 0 || exp_chk_q.size() != 0) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_jk", 32'(exp_jk_q.size()), 32'd0);
    chk("drain_chk", 32'(exp_chk_q.size()), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] diff;
    int m_cnt;
    int start;

    rst       = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    mode      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_cnt", 32'(tog_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_jk", 32'({j, k}), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(tgt_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);

    // hand-computed directed vectors
    send(4'b1010, MODE_JK, 4'b1010, 4'b1010, 4'b1010, 8'd2);
    send(4'b0110, MODE_SR, 4'b0100, 4'b1000, 4'b0110, 8'd2);
    send(4'b0110, MODE_SR, 4'b0000, 4'b0000, 4'b0110, 8'd2);

    // back-to-back JK alternation into counter saturation
    gap_en = 1'b1;
    m_q    = 4'b0110;
    m_cnt  = 2;
    for (int i = 0; i < 70; i++) begin
      d     = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      diff  = d ^ m_q;
      m_cnt = (m_cnt + $countones(diff) > 255) ? 255 : m_cnt + $countones(diff);
      send(d, MODE_JK, diff, diff, d, 8'(m_cnt));
      m_q = d;
    end
    drain();
    gap_en = 1'b0;
    chk("cnt_saturated", 32'(tog_cnt), 32'd255);
    send(4'b0000, MODE_JK, 4'b1111, 4'b1111, 4'b0000, 8'd255);
    drain();

    // tgt_valid held high for 9 edges
    start = n_drive;
    tgt_data = 4'b0000;
    mode     = MODE_JK;
    for (int i = 0; i < 3; i++) begin
      exp_jk_q.push_back(8'h00);
      exp_chk_q.push_back({4'b0000, 1'b0, 8'd255});
    end
    tgt_valid = 1'b1;
    repeat (9) @(posedge clock);
    #1;
    tgt_valid = 1'b0;
    drain();
    chk("accept_count", 32'(n_drive - start), 32'd3);

    // reset asserted in DRIVE aborts the operation
    start     = n_done;
    tgt_data  = 4'b1010;
    mode      = MODE_JK;
    tgt_valid = 1'b1;
    @(posedge clock); #1;
    tgt_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_cnt", 32'(tog_cnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_jk", 32'({j, k}), 32'd0);
    @(posedge clock); #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(tgt_ready), 32'd1);
    repeat (5) @(posedge clock);
    #1;
    chk("abort_no_done", 32'(n_done - start), 32'd0);

    send(4'b0101, MODE_JK, 4'b0101, 4'b0101, 4'b0101, 8'd2);
    drain();
    chk("done_count", 32'(n_done), 32'd78);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
